armips_run_controller: RTL and testbench

Run/step controller for the hybrid ARM/MIPS core on the FPGA board. Converts three raw push-buttons into a clean run, halt, single-step and soft-reset sequence for the processor's `halt`/`reset` inputs. Latches the instruction currently executing so the eight 7-segment digits show a stable value while halted.

---
 rtl/armips_run_ctrl_pkg.sv | 17 +
 rtl/run_ctrl_debounce.sv | 62 ++++++
 rtl/armips_run_controller.sv | 127 ++++++++++++
 tb/tb_armips_run_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/armips_run_ctrl_pkg.sv
// Shared types and defaults for the ARM/MIPS run/step controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package armips_run_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RST  = 2'b00,
        S_HALT = 2'b01,
        S_STEP = 2'b10,
        S_RUN  = 2'b11
    } run_state_t;

    // 10 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEF   = 500000;
    localparam int RESET_HOLD_CYCLES_DEF = 16;

endpackage

// File: rtl/run_ctrl_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability filter, rising-edge press pulse.
// Latency: press is high 2 + DEBOUNCE_CYCLES cycles after the raw level settles.
// Backpressure: none; a press is a single-cycle pulse that the consumer must take or lose.
module run_ctrl_debounce
    import armips_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed from the current one for
    // DEBOUNCE_CYCLES consecutive samples; a sample matching the old level restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/armips_run_controller.sv
// Run/halt/single-step/soft-reset sequencer for the ARM/MIPS core plus display latch;
// optional executed-cycle counter under ARMIPS_RUN_CTRL_CYCLE_CNT_EN.
// Latency: state and outputs update on the edge after a debounced press; no backpressure.
module armips_run_controller
    import armips_run_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int RESET_HOLD_CYCLES = RESET_HOLD_CYCLES_DEF,
    parameter int CNT_W             = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_run,
    input  logic              btn_step,
    input  logic              btn_rst,
    input  logic [31:0]       inst,
    output logic              cpu_halt,
    output logic              cpu_reset,
    output logic [31:0]       inst_shown,
    output logic [1:0]        state
`ifdef ARMIPS_RUN_CTRL_CYCLE_CNT_EN
   ,output logic [CNT_W-1:0]  cycle_count
`endif
);

    localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

    logic       run_press;
    logic       step_press;
    logic       rst_press;
    run_state_t state_q;
    run_state_t state_d;
    logic [HW-1:0] hold_cnt;

    run_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk   (clk),
        .rst_n (reset),
        .btn   (btn_run),
        .press (run_press)
    );

    run_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk   (clk),
        .rst_n (reset),
        .btn   (btn_step),
        .press (step_press)
    );

    run_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
        .clk   (clk),
        .rst_n (reset),
        .btn   (btn_rst),
        .press (rst_press)
    );

    // Next-state logic; soft reset beats run, run beats step.
    always_comb begin
        state_d = state_q;
        if (rst_press) begin
            state_d = S_RST;
        end else begin
            case (state_q)
                S_RST:  if (hold_cnt == HOLD_LAST) state_d = S_HALT;
                S_HALT: begin
                    if (run_press)       state_d = S_RUN;
                    else if (step_press) state_d = S_STEP;
                end
                S_STEP: state_d = S_HALT;
                S_RUN:  if (run_press) state_d = S_HALT;
                default: state_d = S_RST;
            endcase
        end
    end

    // State register with Moore outputs registered from the next state, so
    // outputs always match the state they decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RST;
            cpu_reset <= 1'b1;
            cpu_halt  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cpu_reset <= (state_d == S_RST);
            cpu_halt  <= (state_d == S_RST) || (state_d == S_HALT);
        end
    end

    // Reset hold timer: counts while in S_RST, restarts on any fresh soft reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
        end else if (state_q == S_RST && !rst_press && hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HW'(1);
        end else begin
            hold_cnt <= '0;
        end
    end

    // Display latch: follow the core while it executes, freeze when halted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_shown <= '0;
        end else if (state_d == S_RST) begin
            inst_shown <= '0;
        end else if (!cpu_halt) begin
            inst_shown <= inst;
        end
    end

`ifdef ARMIPS_RUN_CTRL_CYCLE_CNT_EN
    // Executed-cycle counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
        end else if (state_d == S_RST) begin
            cycle_count <= '0;
        end else if (!cpu_halt) begin
            cycle_count <= cycle_count + CNT_W'(1);
        end
    end
`endif

    assign state = state_q;

endmodule

// File: tb/tb_armips_run_controller.sv
// Directed bench for armips_run_controller with DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=4.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: n/a.
module tb_armips_run_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_run;
    logic        btn_step;
    logic        btn_rst;
    logic [31:0] inst;
    logic        cpu_halt;
    logic        cpu_reset;
    logic [31:0] inst_shown;
    logic [1:0]  state;
`ifdef ARMIPS_RUN_CTRL_CYCLE_CNT_EN
    logic [31:0] cycle_count;
`endif

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    armips_run_controller #(
        .DEBOUNCE_CYCLES   (4),
        .RESET_HOLD_CYCLES (4),
        .CNT_W             (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_run    (btn_run),
        .btn_step   (btn_step),
        .btn_rst    (btn_rst),
        .inst       (inst),
        .cpu_halt   (cpu_halt),
        .cpu_reset  (cpu_reset),
        .inst_shown (inst_shown),
        .state      (state)
`ifdef ARMIPS_RUN_CTRL_CYCLE_CNT_EN
       ,.cycle_count(cycle_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Poll on falling edges until state reaches s, giving up after budget cycles.
    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int k = 0;
        while (state !== s && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, {30'd0, state}, {30'd0, s});
    endtask

    initial begin
        int low_cnt;
        int step_cnt;
        int moved;
        int runs;
        logic [31:0] exp_inst;

        reset    = 1'b0;
        btn_run  = 1'b0;
        btn_step = 1'b0;
        btn_rst  = 1'b0;
        inst     = 32'h0;

        // Values held during reset
        repeat (3) @(negedge clk);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_cpu_halt", {31'd0, cpu_halt}, 32'd1);
        check("rst_inst_shown", inst_shown, 32'd0);
`ifdef ARMIPS_RUN_CTRL_CYCLE_CNT_EN
        check("rst_cycle_count", cycle_count, 32'd0);
`endif

        // Four cycles in S_RST after release, then S_HALT
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("hold_state", {30'd0, state}, 32'd0);
            check("hold_cpu_reset", {31'd0, cpu_reset}, 32'd1);
            @(negedge clk);
        end
        check("halt_state", {30'd0, state}, 32'd1);
        check("halt_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        check("halt_cpu_halt", {31'd0, cpu_halt}, 32'd1);
        check("halt_inst_shown", inst_shown, 32'd0);

        // Held step button: exactly one single-cycle step
        inst     = 32'h12345678;
        btn_step = 1'b1;
        low_cnt  = 0;
        step_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 20) btn_step = 1'b0;
            @(negedge clk);
            if (cpu_halt === 1'b0) low_cnt++;
            if (state === 2'b10) step_cnt++;
        end
        check("step_halt_low_cycles", low_cnt, 32'd1);
        check("step_state_cycles", step_cnt, 32'd1);
        check("step_inst_shown", inst_shown, 32'h12345678);
        check("step_back_halt", {30'd0, state}, 32'd1);
`ifdef ARMIPS_RUN_CTRL_CYCLE_CNT_EN
        check("step_cycle_count", cycle_count, 32'd1);
`endif

        // Bounce shorter than the debounce window: no press
        btn_step = 1'b1; @(negedge clk);
        btn_step = 1'b0; @(negedge clk);
        btn_step = 1'b1; @(negedge clk);
        btn_step = 1'b0;
        moved = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (state !== 2'b01 || cpu_halt !== 1'b1) moved++;
        end
        check("bounce_no_press", moved, 32'd0);

        // Run press; step press while running is ignored
        btn_run = 1'b1;
        wait_state(2'b11, 20, "run_enter");
        check("run_cpu_halt", {31'd0, cpu_halt}, 32'd0);
        runs = 1;
`ifdef ARMIPS_RUN_CTRL_CYCLE_CNT_EN
        check("run_entry_count", cycle_count, 32'd1);
`endif
        btn_run  = 1'b0;
        btn_step = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_inst = 32'hA000_0000 + 32'(i);
            inst     = exp_inst;
            @(negedge clk);
            runs++;
            check("run_hold_state", {30'd0, state}, 32'd3);
            check("run_track_inst", inst_shown, exp_inst);
        end
`ifdef ARMIPS_RUN_CTRL_CYCLE_CNT_EN
        check("run_count_step", cycle_count, 32'd9);
`endif

        // Second run press pauses; count and display freeze
        btn_step = 1'b0;
        inst     = 32'hCAFEF00D;
        btn_run  = 1'b1;
        for (int k = 0; k < 20 && state === 2'b11; k++) begin
            @(negedge clk);
            if (state === 2'b11) runs++;
        end
        check("pause_state", {30'd0, state}, 32'd1);
        check("pause_inst_shown", inst_shown, 32'hCAFEF00D);
`ifdef ARMIPS_RUN_CTRL_CYCLE_CNT_EN
        check("pause_count", cycle_count, 32'(1 + runs));
`endif
        inst = 32'h0;
        repeat (3) @(negedge clk);
        check("frozen_inst_shown", inst_shown, 32'hCAFEF00D);
        check("frozen_state", {30'd0, state}, 32'd1);
`ifdef ARMIPS_RUN_CTRL_CYCLE_CNT_EN
        check("frozen_count", cycle_count, 32'(1 + runs));
`endif

        // Back to run, then run and rst rise together: rst wins
        btn_run = 1'b0;
        repeat (10) @(negedge clk);
        btn_run = 1'b1;
        wait_state(2'b11, 20, "run_again");
        btn_run = 1'b0;
        repeat (10) @(negedge clk);
        btn_run = 1'b1;
        btn_rst = 1'b1;
        wait_state(2'b00, 20, "rst_priority");
        check("rst_pri_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_pri_cpu_halt", {31'd0, cpu_halt}, 32'd1);
        check("rst_pri_inst_shown", inst_shown, 32'd0);
`ifdef ARMIPS_RUN_CTRL_CYCLE_CNT_EN
        check("rst_pri_count", cycle_count, 32'd0);
`endif
        btn_run = 1'b0;
        btn_rst = 1'b0;
        repeat (15) @(negedge clk);
        check("rst_then_halt", {30'd0, state}, 32'd1);

        // Async reset during the step cycle acts without a clock edge
        btn_step = 1'b1;
        wait_state(2'b10, 20, "step_enter");
        reset = 1'b0;
        #1;
        check("async_state", {30'd0, state}, 32'd0);
        check("async_cpu_halt", {31'd0, cpu_halt}, 32'd1);
        check("async_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        btn_step = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_halt", {30'd0, state}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
